// File: rtl/demux2_stream.sv
// demux2_stream: 1:2 valid/ready stream demultiplexer.
//
// Each input word goes to one of two output channels, chosen by in_sel. Each channel has
// its own FIFO, so a stalled consumer on one channel never blocks traffic bound for the
// other channel.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      producer handshake; in_sel chooses the channel, in_data is the word
//   out0_* / out1_*        per-channel valid/data/ready consumer handshakes
//   level0 / level1        per-channel FIFO occupancy (0..DEPTH)
//   cnt0 / cnt1            per-channel count of accepted words (wraps)
module demux2_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out0_valid,
  output logic [WIDTH-1:0]         out0_data,
  input  logic                     out0_ready,
  output logic                     out1_valid,
  output logic [WIDTH-1:0]         out1_data,
  input  logic                     out1_ready,
  output logic [$clog2(DEPTH):0]   level0,
  output logic [$clog2(DEPTH):0]   level1,
  output logic [CNT_W-1:0]         cnt0,
  output logic [CNT_W-1:0]         cnt1
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  // Per-channel state, index 0 = channel 0, index 1 = channel 1.
  logic [WIDTH-1:0] mem_q   [2][DEPTH];
  logic [PtrW-1:0]  wptr_q  [2];
  logic [PtrW-1:0]  rptr_q  [2];
  logic [LvlW-1:0]  level_q [2];
  logic [CNT_W-1:0] cnt_q   [2];

  logic [1:0] valid;
  logic [1:0] full;
  logic [1:0] ready;
  logic [1:0] push;
  logic [1:0] pop;

  assign ready = {out1_ready, out0_ready};

  // in_ready depends only on registered occupancy and in_sel; a full channel never
  // accepts, even if it is being popped in the same cycle.
  always_comb begin
    valid    = '0;
    full     = '0;
    push     = '0;
    for (int c = 0; c < 2; c++) begin
      valid[c] = (level_q[c] != '0);
      full[c]  = (level_q[c] == LvlFull);
    end
    in_ready = !reset && !full[in_sel];
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
    pop = valid & ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        level_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          wptr_q[c] <= wptr_q[c] + 1'b1;
          cnt_q[c]  <= cnt_q[c] + 1'b1;
        end
        if (pop[c]) begin
          rptr_q[c] <= rptr_q[c] + 1'b1;
        end
        // Push and pop together leave the level unchanged.
        level_q[c] <= level_q[c] + LvlW'(push[c]) - LvlW'(pop[c]);
      end
    end
  end

  // Storage needs no reset: contents are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_q[c][wptr_q[c]] <= in_data;
      end
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = mem_q[0][rptr_q[0]];
  assign out1_data  = mem_q[1][rptr_q[1]];
  assign level0     = level_q[0];
  assign level1     = level_q[1];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Directed self-checking bench for demux2_stream (WIDTH=8, DEPTH=4, CNT_W=8).
// Inputs change just after the falling edge; checks are taken 1 time unit later,
// well away from the rising edge where the DUT updates.
module tb_demux2_stream;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_sel;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out0_valid;
  logic [7:0] out0_data;
  logic       out0_ready;
  logic       out1_valid;
  logic [7:0] out1_data;
  logic       out1_ready;
  logic [2:0] level0;
  logic [2:0] level1;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int n_tests;
  int n_fail;

  demux2_stream #(
    .WIDTH(8),
    .DEPTH(4),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out0_valid(out0_valid),
    .out0_data (out0_data),
    .out0_ready(out0_ready),
    .out1_valid(out1_valid),
    .out1_data (out1_data),
    .out1_ready(out1_ready),
    .level0    (level0),
    .level1    (level1),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs set after this apply to the next rising edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_v0"}, 32'(out0_valid), 32'd0);
    check({tag, "_v1"}, 32'(out1_valid), 32'd0);
    check({tag, "_l0"}, 32'(level0), 32'd0);
    check({tag, "_l1"}, 32'(level1), 32'd0);
    check({tag, "_c0"}, 32'(cnt0), 32'd0);
    check({tag, "_c1"}, 32'(cnt1), 32'd0);
  endtask

  int sent;
  int got;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 8'h77;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // ---- Reset: two cycles with in_valid high, in_ready must stay low.
    tick(); #1;
    check("rst_rdy_a", 32'(in_ready), 32'd0);
    tick(); #1;
    check("rst_rdy_b", 32'(in_ready), 32'd0);
    check_empty("rst");
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_rdy_after", 32'(in_ready), 32'd1);

    // ---- Basic routing, both consumers ready.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
    #1 check("rt_rdy", 32'(in_ready), 32'd1);
    tick();
    in_sel = 1'b1; in_data = 8'h22;
    #1;
    check("rt_v0_a", 32'(out0_valid), 32'd1);
    check("rt_d0_a", 32'(out0_data), 32'h11);
    check("rt_v1_a", 32'(out1_valid), 32'd0);
    tick();
    in_sel = 1'b0; in_data = 8'h33;
    #1;
    check("rt_v0_b", 32'(out0_valid), 32'd0);
    check("rt_v1_b", 32'(out1_valid), 32'd1);
    check("rt_d1_b", 32'(out1_data), 32'h22);
    tick();
    in_valid = 1'b0;
    #1;
    check("rt_v0_c", 32'(out0_valid), 32'd1);
    check("rt_d0_c", 32'(out0_data), 32'h33);
    check("rt_v1_c", 32'(out1_valid), 32'd0);
    tick(); #1;
    check("rt_v0_d", 32'(out0_valid), 32'd0);
    check("rt_cnt0", 32'(cnt0), 32'd2);
    check("rt_cnt1", 32'(cnt1), 32'd1);

    // ---- Full/stall isolation: channel 0 blocked, channel 1 still flows.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hB0 + 8'(i);
      #1 check($sformatf("st_rdy%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    check("st_l0_full", 32'(level0), 32'd4);
    in_sel = 1'b1; in_data = 8'hA5;
    #1 check("st_rdy_sw", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("st_v1", 32'(out1_valid), 32'd1);
    check("st_d1", 32'(out1_data), 32'hA5);
    check("st_d0_frozen", 32'(out0_data), 32'hB0);
    check("st_l0", 32'(level0), 32'd4);
    check("st_l1", 32'(level1), 32'd1);
    out1_ready = 1'b1;
    tick(); #1;
    check("st_v1_drained", 32'(out1_valid), 32'd0);
    check("st_d0_still", 32'(out0_data), 32'hB0);

    // ---- Full with simultaneous pop: no bypass, push waits one cycle.
    out0_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hC0;
    #1 check("fp_rdy_full", 32'(in_ready), 32'd0);
    tick(); #1;
    check("fp_l0_a", 32'(level0), 32'd3);
    check("fp_rdy_b", 32'(in_ready), 32'd1);
    check("fp_d0_b", 32'(out0_data), 32'hB1);
    tick();
    in_valid = 1'b0;
    #1;
    check("fp_l0_c", 32'(level0), 32'd3);
    check("fp_d0_c", 32'(out0_data), 32'hB2);
    tick(); #1 check("fp_d0_d", 32'(out0_data), 32'hB3);
    tick(); #1 check("fp_d0_e", 32'(out0_data), 32'hC0);
    tick(); #1;
    check("fp_v0_empty", 32'(out0_valid), 32'd0);
    check("fp_cnt0", 32'(cnt0), 32'd7);
    check("fp_cnt1", 32'(cnt1), 32'd2);

    // ---- Wrap-around: fresh reset, then 259 words to channel 1 with a toggling consumer.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 3000 && got < 259; cyc++) begin
      tick();
      out1_ready = cyc[0];
      in_valid   = (sent < 259);
      in_sel     = 1'b1;
      in_data    = sent[7:0];
      #1;
      if (out1_valid && out1_ready) begin
        check("wrap_data", 32'(out1_data), 32'(got[7:0]));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    tick();
    in_valid   = 1'b0;
    out1_ready = 1'b0;
    #1;
    check("wrap_sent", 32'(sent), 32'd259);
    check("wrap_got", 32'(got), 32'd259);
    check("wrap_cnt1", 32'(cnt1), 32'd3);
    check("wrap_cnt0", 32'(cnt0), 32'd0);
    check("wrap_l1", 32'(level1), 32'd0);
    check("wrap_v1", 32'(out1_valid), 32'd0);

    // ---- Reset mid-operation with level0 = 3, level1 = 2.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sel   = (i >= 3);
      in_data  = 8'hD0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("mr_l0", 32'(level0), 32'd3);
    check("mr_l1", 32'(level1), 32'd2);
    reset = 1'b1;
    #1 check("mr_rdy_rst", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_empty("mr");
    out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    #1;
    check("mr_v1", 32'(out1_valid), 32'd1);
    check("mr_d1", 32'(out1_data), 32'h5A);
    check("mr_l1_one", 32'(level1), 32'd1);
    check("mr_v0", 32'(out0_valid), 32'd0);
    tick(); #1;
    check("mr_v1_after", 32'(out1_valid), 32'd0);
    check("mr_cnt1", 32'(cnt1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
